// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous-read data memory between the pipelined core data
// interface (absolute priority, zero added latency) and a secondary requester
// (loader / debug DMA) buffered in a one-entry request register. The buffered
// request issues only in cycles where the core performs no load/store.
//
// Optional feature: define DMEM_ARB_STARVE_EN to add a saturating counter of
// blocked cycles that drives o_starve. Without it o_starve is tied low.
//
// Ports:
//   i_clk, i_rst_n                clock, asynchronous active-low reset
//   i_core_req/addr/wr_data/      core EX-stage access (mask: 00 byte,
//   i_core_mask/i_core_wr_en      01 half, 10 word)
//   o_core_rd_data                memory read data to core WB
//   i_sec_req, o_sec_ready        secondary request handshake
//   i_sec_we/addr/wdata/mask      secondary request payload
//   o_sec_rvalid, o_sec_rdata     secondary read response (1-cycle pulse)
//   o_starve                      secondary blocked >= STARVE_LIMIT cycles
//   o_mem_addr/wr_data/mask/      memory macro request
//   o_mem_wr_en
//   i_mem_rd_data                 memory read data, one cycle after address
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_core_req,
    input  logic [XLEN-1:0] i_core_addr,
    input  logic [XLEN-1:0] i_core_wr_data,
    input  logic [1:0]      i_core_mask,
    input  logic            i_core_wr_en,
    output logic [XLEN-1:0] o_core_rd_data,
    input  logic            i_sec_req,
    output logic            o_sec_ready,
    input  logic            i_sec_we,
    input  logic [XLEN-1:0] i_sec_addr,
    input  logic [XLEN-1:0] i_sec_wdata,
    input  logic [1:0]      i_sec_mask,
    output logic            o_sec_rvalid,
    output logic [XLEN-1:0] o_sec_rdata,
    output logic            o_starve,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wr_data,
    output logic [1:0]      o_mem_mask,
    output logic            o_mem_wr_en,
    input  logic [XLEN-1:0] i_mem_rd_data
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_buf_we;
    logic [XLEN-1:0] r_buf_addr;
    logic [XLEN-1:0] r_buf_wdata;
    logic [1:0]      r_buf_mask;

    logic            w_accept;
    logic            w_issue;

    // Buffer is free everywhere except while holding an unissued request.
    assign o_sec_ready    = (r_state != ST_PENDING);
    assign w_accept       = i_sec_req & o_sec_ready;

    // Read data is shared; each consumer qualifies it on its own.
    assign o_core_rd_data = i_mem_rd_data;
    assign o_sec_rdata    = i_mem_rd_data;
    assign o_sec_rvalid   = (r_state == ST_RD_WAIT);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory mux; core owns the memory unless the buffer issues.
    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        o_mem_addr    = i_core_addr;
        o_mem_wr_data = i_core_wr_data;
        o_mem_mask    = i_core_mask;
        o_mem_wr_en   = i_core_req & i_core_wr_en;

        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!i_core_req) begin
                    w_issue       = 1'b1;
                    o_mem_addr    = r_buf_addr;
                    o_mem_wr_data = r_buf_wdata;
                    o_mem_mask    = r_buf_mask;
                    o_mem_wr_en   = r_buf_we;
                    w_state_nxt   = r_buf_we ? ST_EMPTY : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                w_state_nxt = w_accept ? ST_PENDING : ST_EMPTY;
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // One-entry request buffer; requester need not hold inputs after accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_we    <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_wdata <= '0;
            r_buf_mask  <= 2'b00;
        end else if (w_accept) begin
            r_buf_we    <= i_sec_we;
            r_buf_addr  <= i_sec_addr;
            r_buf_wdata <= i_sec_wdata;
            r_buf_mask  <= i_sec_mask;
        end
    end

`ifdef DMEM_ARB_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_cnt_nxt;
    logic             r_starve;

    // Count blocked cycles, saturating at the limit; an issue clears it.
    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (w_issue) begin
            w_starve_cnt_nxt = '0;
        end else if ((r_state == ST_PENDING) && i_core_req &&
                     (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_starve     <= (w_starve_cnt_nxt == CNT_W'(STARVE_LIMIT));
        end
    end

    assign o_starve = r_starve;
`else
    logic w_unused_starve;

    // Starvation monitor compiled out; issue strobe and limit have no load.
    assign w_unused_starve = w_issue ^ (^32'(STARVE_LIMIT));
    assign o_starve        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A behavioural synchronous-read memory
// hangs off o_mem_*; a shadow map of every write driven by the bench supplies
// expected read data, pushed to a queue when a secondary read is accepted and
// popped when o_sec_rvalid appears. Inputs change #1 after posedge, outputs
// are sampled on negedge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LIMIT = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            core_req, core_wr_en;
    logic [XLEN-1:0] core_addr, core_wr_data, core_rd_data;
    logic [1:0]      core_mask;
    logic            sec_req, sec_ready, sec_we, sec_rvalid;
    logic [XLEN-1:0] sec_addr, sec_wdata, sec_rdata;
    logic [1:0]      sec_mask;
    logic            starve;
    logic [XLEN-1:0] mem_addr, mem_wr_data;
    logic [XLEN-1:0] mem_rd_data = '0;
    logic [1:0]      mem_mask;
    logic            mem_wr_en;

    int n_cmp = 0;
    int n_bad = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] shadow[int];
    logic [XLEN-1:0] mem[0:255];

    always #5 clk = ~clk;

    // Word-wide synchronous-read memory model.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wr_data;
        mem_rd_data <= mem[mem_addr[9:2]];
    end

    dmem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_core_req(core_req), .i_core_addr(core_addr),
        .i_core_wr_data(core_wr_data), .i_core_mask(core_mask),
        .i_core_wr_en(core_wr_en), .o_core_rd_data(core_rd_data),
        .i_sec_req(sec_req), .o_sec_ready(sec_ready), .i_sec_we(sec_we),
        .i_sec_addr(sec_addr), .i_sec_wdata(sec_wdata), .i_sec_mask(sec_mask),
        .o_sec_rvalid(sec_rvalid), .o_sec_rdata(sec_rdata), .o_starve(starve),
        .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wr_data),
        .o_mem_mask(mem_mask), .o_mem_wr_en(mem_wr_en),
        .i_mem_rd_data(mem_rd_data)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        core_req = 1'b0; core_wr_en = 1'b0;
        core_addr = 32'h0; core_wr_data = 32'h0; core_mask = 2'b10;
    endtask

    task automatic test_reset();
        core_idle();
        sec_req = 1'b0; sec_we = 1'b0; sec_addr = 32'h0;
        sec_wdata = 32'h0; sec_mask = 2'b10;
        @(negedge clk);
        n_cmp++; if (sec_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", sec_ready); end
        n_cmp++; if (sec_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got %b want 0", sec_rvalid); end
        n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL reset_starve got %b want 0", starve); end
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_core_store();
        core_req = 1'b1; core_wr_en = 1'b1; core_addr = 32'h100;
        core_wr_data = 32'hDEADBEEF; core_mask = 2'b10;
        shadow[32'h100] = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (mem_wr_en !== 1'b1) begin n_bad++; $display("FAIL core_st_wr_en got %b want 1", mem_wr_en); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL core_st_addr got %h want 00000100", mem_addr); end
        n_cmp++; if (mem_wr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL core_st_data got %h want deadbeef", mem_wr_data); end
        n_cmp++; if (mem_mask !== 2'b10) begin n_bad++; $display("FAIL core_st_mask got %b want 10", mem_mask); end
        next_cycle();
        core_wr_en = 1'b0; core_mask = 2'b01;
        @(negedge clk);
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL core_ld_wr_en got %b want 0", mem_wr_en); end
        n_cmp++; if (mem_mask !== 2'b01) begin n_bad++; $display("FAIL core_ld_mask got %b want 01", mem_mask); end
        next_cycle();
        core_idle();
        @(negedge clk);
        n_cmp++; if (core_rd_data !== shadow[32'h100]) begin n_bad++; $display("FAIL core_ld_data got %h want %h", core_rd_data, shadow[32'h100]); end
        next_cycle();
    endtask

    task automatic test_sec_write();
        sec_req = 1'b1; sec_we = 1'b1; sec_addr = 32'h200;
        sec_wdata = 32'h12345678; sec_mask = 2'b10;
        shadow[32'h200] = 32'h12345678;
        @(negedge clk);
        n_cmp++; if (sec_ready !== 1'b1) begin n_bad++; $display("FAIL swr_ready_t got %b want 1", sec_ready); end
        next_cycle();
        sec_req = 1'b0; sec_addr = 32'hFFF0; sec_wdata = 32'h0; sec_mask = 2'b00;
        @(negedge clk);
        n_cmp++; if (mem_wr_en !== 1'b1) begin n_bad++; $display("FAIL swr_wr_en got %b want 1", mem_wr_en); end
        n_cmp++; if (mem_addr !== 32'h200) begin n_bad++; $display("FAIL swr_addr got %h want 00000200", mem_addr); end
        n_cmp++; if (mem_wr_data !== 32'h12345678) begin n_bad++; $display("FAIL swr_data got %h want 12345678", mem_wr_data); end
        n_cmp++; if (mem_mask !== 2'b10) begin n_bad++; $display("FAIL swr_mask got %b want 10", mem_mask); end
        n_cmp++; if (sec_ready !== 1'b0) begin n_bad++; $display("FAIL swr_ready_t1 got %b want 0", sec_ready); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (sec_ready !== 1'b1) begin n_bad++; $display("FAIL swr_ready_t2 got %b want 1", sec_ready); end
        n_cmp++; if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL swr_wr_en_t2 got %b want 0", mem_wr_en); end
        n_cmp++; if (sec_rvalid !== 1'b0) begin n_bad++; $display("FAIL swr_rvalid got %b want 0", sec_rvalid); end
        next_cycle();
    endtask

    task automatic test_sec_read_blocked();
        logic [XLEN-1:0] exp;
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 32'h200; sec_mask = 2'b10;
        next_cycle();
        sec_req = 1'b0; sec_addr = 32'h0;
        exp_q.push_back(shadow[32'h200]);
        core_req = 1'b1; core_addr = 32'h100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL blk_addr[%0d] got %h want 00000100", k, mem_addr); end
            n_cmp++; if (sec_ready !== 1'b0 || sec_rvalid !== 1'b0) begin n_bad++; $display("FAIL blk_state[%0d] got ready=%b rvalid=%b want 0/0", k, sec_ready, sec_rvalid); end
            next_cycle();
        end
        core_idle();
        @(negedge clk);
        n_cmp++; if (mem_addr !== 32'h200 || mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL blk_issue got addr=%h we=%b want 00000200/0", mem_addr, mem_wr_en); end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (sec_rvalid !== 1'b1) begin
            n_bad++; $display("FAIL blk_rvalid got %b want 1", sec_rvalid);
        end else begin
            exp = exp_q.pop_front();
            if (sec_rdata !== exp) begin n_bad++; $display("FAIL blk_rdata got %h want %h", sec_rdata, exp); end
        end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (sec_rvalid !== 1'b0) begin n_bad++; $display("FAIL blk_rvalid_pulse got %b want 0", sec_rvalid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int  n_hs;
        int  n_rv;
        int  last_rv;
        int  cyc;
        logic hs;
        logic [XLEN-1:0] exp;
        // Four consecutive writes with the request held high.
        n_hs = 0; cyc = 0;
        sec_req = 1'b1; sec_we = 1'b1; sec_addr = 32'h300; sec_wdata = 32'hA0000000;
        while (n_hs < 4 && cyc < 20) begin
            @(negedge clk);
            hs = sec_ready & sec_req;
            next_cycle();
            cyc++;
            if (hs) begin
                shadow[int'(sec_addr)] = sec_wdata;
                n_hs++;
                sec_addr = sec_addr + 32'h4;
                sec_wdata = sec_wdata + 32'h1111;
                if (n_hs == 4) sec_req = 1'b0;
            end
        end
        n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL b2b_wr_cycles got %0d want 7", cyc); end
        next_cycle();
        // Four consecutive reads; expect one rvalid every two cycles.
        n_hs = 0; n_rv = 0; last_rv = -1; cyc = 0;
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 32'h300;
        while (n_rv < 4 && cyc < 20) begin
            @(negedge clk);
            if (sec_rvalid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_rdata got %h want none", sec_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (sec_rdata !== exp) begin n_bad++; $display("FAIL b2b_rdata[%0d] got %h want %h", n_rv, sec_rdata, exp); end
                end
                if (last_rv >= 0) begin
                    n_cmp++; if (cyc - last_rv != 2) begin n_bad++; $display("FAIL b2b_spacing got %0d want 2", cyc - last_rv); end
                end
                last_rv = cyc;
                n_rv++;
            end
            hs = sec_ready & sec_req;
            next_cycle();
            cyc++;
            if (hs) begin
                exp_q.push_back(shadow[int'(sec_addr)]);
                n_hs++;
                sec_addr = sec_addr + 32'h4;
                if (n_hs == 4) sec_req = 1'b0;
            end
        end
        n_cmp++; if (n_rv != 4) begin n_bad++; $display("FAIL b2b_rv_count got %0d want 4", n_rv); end
        next_cycle();
    endtask

    task automatic test_starve();
        logic [XLEN-1:0] exp;
        logic want;
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 32'h304;
        next_cycle();
        sec_req = 1'b0;
        exp_q.push_back(shadow[32'h304]);
        core_req = 1'b1; core_addr = 32'h100;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            want = STARVE_ON && (k > int'(LIMIT));
            n_cmp++; if (starve !== want) begin n_bad++; $display("FAIL starve_blk[%0d] got %b want %b", k, starve, want); end
            next_cycle();
        end
        core_idle();
        @(negedge clk);
        n_cmp++; if (mem_addr !== 32'h304) begin n_bad++; $display("FAIL starve_issue got %h want 00000304", mem_addr); end
        n_cmp++; if (starve !== STARVE_ON) begin n_bad++; $display("FAIL starve_issue_flag got %b want %b", starve, STARVE_ON); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL starve_clear got %b want 0", starve); end
        n_cmp++;
        if (sec_rvalid !== 1'b1) begin
            n_bad++; $display("FAIL starve_rvalid got %b want 1", sec_rvalid);
        end else begin
            exp = exp_q.pop_front();
            if (sec_rdata !== exp) begin n_bad++; $display("FAIL starve_rdata got %h want %h", sec_rdata, exp); end
        end
        next_cycle();
    endtask

    task automatic test_reset_pending();
        sec_req = 1'b1; sec_we = 1'b0; sec_addr = 32'h300;
        next_cycle();
        sec_req = 1'b0;
        core_req = 1'b1; core_addr = 32'h100;
        @(negedge clk);
        n_cmp++; if (sec_ready !== 1'b0) begin n_bad++; $display("FAIL rstp_pending got %b want 0", sec_ready); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (sec_ready !== 1'b1 || sec_rvalid !== 1'b0) begin n_bad++; $display("FAIL rstp_in_reset got ready=%b rvalid=%b want 1/0", sec_ready, sec_rvalid); end
        next_cycle();
        rst_n = 1'b1;
        core_idle();
        core_addr = 32'h44;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (sec_rvalid !== 1'b0 || mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL rstp_quiet[%0d] got rvalid=%b we=%b want 0/0", k, sec_rvalid, mem_wr_en); end
            n_cmp++; if (mem_addr !== 32'h44 || sec_ready !== 1'b1) begin n_bad++; $display("FAIL rstp_mux[%0d] got addr=%h ready=%b want 00000044/1", k, mem_addr, sec_ready); end
            next_cycle();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_core_store();
        test_sec_write();
        test_sec_read_blocked();
        test_back_to_back();
        test_starve();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single synchronous-read data memory between the pipelined core's data interface and a secondary requester (program loader / debug DMA). The core has no stall input, so it always has absolute priority. The secondary port is buffered in a one-entry request register and issued only in cycles where the core makes no load/store. The block sits between the core data interface and the data memory macro, and optionally flags secondary starvation.

## Interface
Parameters:
- XLEN, 32, address/data width
- STARVE_LIMIT, 64, consecutive blocked cycles before `o_starve` asserts (≥1)

Ports:
- Clock and reset: one clock, `i_clk`; asynchronous active-low reset, `i_rst_n`.
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  asynchronous active-low reset
- `i_core_req`  in  1  core EX stage performs load or store this cycle
- `i_core_addr`  in  XLEN  core byte address
- `i_core_wr_data`  in  XLEN  core store data
- `i_core_mask`  in  2  access size: 00 byte, 01 half, 10 word
- `i_core_wr_en`  in  1  core store
- `o_core_rd_data`  out  XLEN  memory read data to core WB (= `i_mem_rd_data`)
- `i_sec_req`  in  1  secondary request valid
- `o_sec_ready`  out  1  request buffer can accept
- `i_sec_we`  in  1  secondary write
- `i_sec_addr`  in  XLEN  secondary byte address
- `i_sec_wdata`  in  XLEN  secondary write data
- `i_sec_mask`  in  2  secondary access size, same encoding
- `o_sec_rvalid`  out  1  secondary read data valid (1-cycle pulse)
- `o_sec_rdata`  out  XLEN  secondary read data
- `o_starve`  out  1  secondary request blocked ≥ STARVE_LIMIT cycles
- `o_mem_addr`, `o_mem_wr_data`  out  XLEN  memory address / write data
- `o_mem_mask`  out  2  memory access size
- `o_mem_wr_en`  out  1  memory write strobe
- `i_mem_rd_data`  in  XLEN  memory read data, valid the cycle after its address

## Operation
- FSM states: EMPTY, PENDING, RD_WAIT. Reset → EMPTY.
- Accept: `i_sec_req & o_sec_ready` at a clock edge captures we/addr/wdata/mask into the buffer → PENDING. `o_sec_ready = (state != PENDING)`.
- PENDING with `i_core_req=1`: core drives memory; buffer holds; stay PENDING.
- PENDING with `i_core_req=0`: buffer drives `o_mem_*` combinationally; `o_mem_wr_en = buf_we`. Next state: write → EMPTY; read → RD_WAIT.
- RD_WAIT: `o_sec_rvalid=1`, `o_sec_rdata=i_mem_rd_data`. Leaves after one cycle → EMPTY, or → PENDING if a new request is accepted in the same cycle.
- EMPTY / RD_WAIT / PENDING-blocked: memory mux selects core; `o_mem_wr_en = i_core_req & i_core_wr_en`.
- `o_core_rd_data` is always `i_mem_rd_data`. The core discards it in cycles following a non-access.
- Addresses and masks pass through unmodified. No alignment checking or address decoding; MMIO filtering stays upstream.
- Reset mid-operation: buffered request dropped, no `o_sec_rvalid`, no memory write.

## Timing
- Reset values: `o_sec_ready=1`, `o_sec_rvalid=0`, `o_sec_rdata=i_mem_rd_data`, `o_starve=0`. `o_mem_*` follow core inputs, with `o_mem_wr_en = i_core_req & i_core_wr_en`.
- Core path: zero added latency, combinational mux only. Core read data arrives at t+1 as without the arbiter.
- Secondary best case: accept at edge t, issue in cycle t+1, `o_sec_rvalid` in cycle t+2. A write completes at the end of cycle t+1.
- `o_sec_ready` is 0 only in PENDING. Throughput: one secondary access per 2 cycles for reads and one per 2 cycles for writes (accept, issue).
- Simultaneous core request and buffer issue: the core always wins; the buffer issues no earlier than the first core-idle cycle.
- Secondary request inputs need not be held after acceptance.

## Configuration
- `DMEM_ARB_STARVE_EN` defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments each cycle the block is PENDING with `i_core_req=1`.
  - The counter saturates at STARVE_LIMIT and clears on issue or reset.
  - `o_starve = (count == STARVE_LIMIT)`, registered.
- `DMEM_ARB_STARVE_EN` undefined: no counter; `o_starve` tied 0.

## Test plan
- Reset, idle: `o_sec_ready=1`, `o_sec_rvalid=0`, `o_starve=0`. Core store addr 0x100, data 0xDEADBEEF, mask 10 → `o_mem_wr_en=1` same cycle, `o_mem_addr=0x100`.
- Secondary write 0x200 = 0x12345678 with core idle: accepted at t, `o_mem_wr_en=1`/`o_mem_addr=0x200` in t+1, `o_sec_ready=1` again at t+2.
- Secondary read 0x200 with `i_core_req=1` for 3 cycles after acceptance: no secondary issue during those cycles. Issue in the 4th cycle, `o_sec_rvalid=1` with 0x12345678 the cycle after.
- Back-to-back reads: a new request is accepted during RD_WAIT → one rvalid per 2 cycles, correct data order.
- With `DMEM_ARB_STARVE_EN`, STARVE_LIMIT=4: core busy continuously → `o_starve=1` after 4 blocked cycles. Core idles → issue, `o_starve=0` next cycle. Without the macro → `o_starve` stays 0.
- Reset asserted in PENDING (read buffered): after release, state EMPTY, `o_sec_ready=1`, no `o_sec_rvalid`, no memory write.
